// File: rtl/persiana_cmd_scheduler.sv
// Blind command scheduler: arbitrates manual/auto targets and sequences the
// up/down motor with dead time, travel timeout and limit-sensor position tracking.
module persiana_cmd_scheduler #(
  parameter int unsigned PRESC_MAX     = 16777215,
  parameter int unsigned DEAD_TICKS    = 2,
  parameter int unsigned TIMEOUT_TICKS = 20,
  parameter int unsigned AUTO_STABLE   = 3
) (
  input  logic       clk,
  input  logic       reseteo,
  input  logic       ena,
  input  logic [2:0] man_cmd,
  input  logic [1:0] sensor,
  input  logic       s_sup,
  input  logic       s_med,
  input  logic       s_inf,
  output logic       subir,
  output logic       bajar,
  output logic       tick,
  output logic       busy,
  output logic       fault,
  output logic [1:0] pos
);

  localparam int PW = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DEAD  = 3'd1;
  localparam logic [2:0] S_UP    = 3'd2;
  localparam logic [2:0] S_DOWN  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [PW-1:0] presc;
  logic [2:0]    state;
  logic [1:0]    target;
  logic          up;
  logic          auto_mode, armed;
  logic [2:0]    man_prev;
  logic [1:0]    sens_prev;
  logic [15:0]   dead_cnt, to_cnt, sens_cnt;

  // {needs_motion, up} for target t starting from position p
  function automatic logic [1:0] plan(input logic [1:0] t, input logic [1:0] p);
    logic [1:0] r;
    r = 2'b00;
    case (t)
      2'b11:   r = (p == 2'b11) ? 2'b00 : 2'b11;
      2'b01:   r = (p == 2'b01) ? 2'b00 : 2'b10;
      2'b10:   r = (p == 2'b10) ? 2'b00 : (p == 2'b01) ? 2'b11 : 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  logic       multi, any_s, man_move, auto_hit, req_v, tgt_hit, lim_hit;
  logic [1:0] pos_snap, req_t, rp, lp;

  always_comb begin
    multi    = (s_sup & s_med) | (s_sup & s_inf) | (s_med & s_inf);
    any_s    = s_sup | s_med | s_inf;
    pos_snap = s_inf ? 2'b01 : s_med ? 2'b10 : 2'b11;
    man_move = (man_cmd == 3'b001 || man_cmd == 3'b010 || man_cmd == 3'b011) &&
               (man_cmd != man_prev);
    auto_hit = auto_mode && tick && armed && (sensor == sens_prev) &&
               (sensor != 2'b00) && (sens_cnt == 16'(AUTO_STABLE - 1));
    // manual move beats an auto acceptance in the same cycle
    req_v    = man_move | auto_hit;
    req_t    = man_move ? man_cmd[1:0] : sensor;
    rp       = plan(req_t, pos);
    lp       = plan(target, up ? 2'b11 : 2'b01);
    tgt_hit  = (target == 2'b01 && s_inf) || (target == 2'b10 && s_med) ||
               (target == 2'b11 && s_sup);
    lim_hit  = up ? s_sup : s_inf;
  end

  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      presc     <= '0;
      tick      <= 1'b0;
      state     <= S_IDLE;
      target    <= 2'b00;
      up        <= 1'b0;
      pos       <= 2'b00;
      auto_mode <= 1'b0;
      armed     <= 1'b1;
      man_prev  <= 3'b000;
      sens_prev <= 2'b00;
      dead_cnt  <= '0;
      to_cnt    <= '0;
      sens_cnt  <= '0;
    end else begin
      presc     <= (presc == PW'(PRESC_MAX)) ? '0 : presc + 1'b1;
      tick      <= (presc == PW'(PRESC_MAX));
      man_prev  <= man_cmd;
      sens_prev <= sensor;
      if (any_s && !multi) pos <= pos_snap;

      if (man_move)               auto_mode <= 1'b0;
      else if (man_cmd == 3'b100) auto_mode <= 1'b1;

      if (!auto_mode || sensor != sens_prev) begin
        sens_cnt <= '0;
        armed    <= 1'b1;
      end else if (auto_hit) begin
        sens_cnt <= '0;
        armed    <= 1'b0;
      end else if (tick && armed && sensor != 2'b00) begin
        sens_cnt <= sens_cnt + 16'd1;
      end

      if (state == S_FAULT) begin
        state <= S_FAULT;
      end else if (!ena) begin
        state    <= S_IDLE;
        target   <= 2'b00;
        dead_cnt <= '0;
        to_cnt   <= '0;
      end else if (multi) begin
        state <= S_FAULT;
      end else begin
        case (state)
          S_IDLE: if (req_v && rp[1]) begin
            target   <= req_t;
            up       <= rp[0];
            dead_cnt <= '0;
            state    <= S_DEAD;
          end
          S_DEAD: begin
            if (req_v && !rp[1]) begin
              target <= req_t;
              state  <= S_IDLE;
            end else if (req_v && rp[0] != up) begin
              target   <= req_t;
              up       <= rp[0];
              dead_cnt <= '0;
            end else begin
              if (req_v) target <= req_t;
              if (tick) begin
                if (dead_cnt == 16'(DEAD_TICKS - 1)) begin
                  dead_cnt <= '0;
                  to_cnt   <= '0;
                  state    <= up ? S_UP : S_DOWN;
                end else begin
                  dead_cnt <= dead_cnt + 16'd1;
                end
              end
            end
          end
          S_UP, S_DOWN: begin
            if (req_v) begin
              target <= req_t;
              if (!rp[1]) state <= S_IDLE;
              else if (rp[0] != up) begin
                up       <= rp[0];
                dead_cnt <= '0;
                state    <= S_DEAD;
              end
            end else if (tgt_hit) begin
              state <= S_IDLE;
            end else if (lim_hit) begin
              up       <= lp[0];
              dead_cnt <= '0;
              state    <= lp[1] ? S_DEAD : S_IDLE;
            end else if (tick) begin
              if (to_cnt == 16'(TIMEOUT_TICKS - 1)) state <= S_FAULT;
              else to_cnt <= to_cnt + 16'd1;
            end
          end
          default: state <= S_FAULT;
        endcase
      end
    end
  end

  // motor outputs decode straight from state so reset kills them at once
  assign subir = (state == S_UP);
  assign bajar = (state == S_DOWN);
  assign busy  = (state == S_DEAD) || (state == S_UP) || (state == S_DOWN);
  assign fault = (state == S_FAULT);

endmodule
